lcd_read_engine: RTL
====================

Name: lcd_read_engine

Overview:
- Read-side counterpart of the LCD write path: runs HD44780 read cycles on the shared character-LCD bus.
  - RS=0: status read, returning the busy flag (BF) and address counter (AC).
  - RS=1: data read from DDRAM/CGRAM.
- Optional poll mode repeats status reads until BF clears, with a timeout.
- Sits beside lcd_top_level. The top level grants it the bus while rd_active=1 and tri-states LCD_DATA during that time. Timing targets CLOCK2_50 (20 ns period).

Parameters:
- SETUP_CYC, 3: RS/RW setup cycles before EN rises (60 ns ≥ tAS 40 ns).
- EN_HIGH_CYC, 12: EN high width in cycles (240 ns ≥ PWEH 230 ns).
- HOLD_CYC, 2: cycles after EN falls with RS/RW held (40 ns ≥ tH).
- RECOVER_CYC, 10: bus-idle cycles before done; full transaction ≥ 500 ns tcycE.
- POLL_MAX, 4096: maximum status reads in poll mode before timeout.

Ports:
- clk  in  1  system clock (CLOCK2_50 at top level)
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- rs_sel  in  1  0 = status read, 1 = data read; latched at accept
- poll  in  1  1 = repeat status reads until BF=0; latched at accept, ignored when rs_sel=1
- lcd_data_in  in  8  LCD_DATA pad input
- lcd_en  out  1  LCD enable strobe
- lcd_rs  out  1  register select
- lcd_rw  out  1  1 = read
- rd_active  out  1  engine owns the bus; top level disables its LCD_DATA driver
- busy  out  1  transaction in progress (state ≠ IDLE)
- done  out  1  one-cycle completion pulse
- rdata  out  8  last sampled byte
- busy_flag  out  1  rdata[7] of the last status read
- addr  out  7  rdata[6:0] of the last status read
- timeout  out  1  poll ended without BF=0; valid with done, held until next accept
- poll_count  out  13  status reads issued in the current or last poll

Behaviour:
- Reset (async, immediate): state=IDLE; lcd_en=0, lcd_rs=0, lcd_rw=0, rd_active=0, busy=0, done=0, rdata=0, busy_flag=0, addr=0, timeout=0, poll_count=0. Reset wins over a simultaneous start.
- States: IDLE → SETUP → EN_HI → HOLD → RECOVER → IDLE, or RECOVER → SETUP when poll continues.
- IDLE:
  - start=1 at an edge: latch rs_sel/poll, clear timeout, set poll_count=0, go to SETUP.
  - start in any other state is ignored, with no queuing.
- SETUP (SETUP_CYC cycles): rd_active=1, lcd_rw=1, lcd_rs=latched rs_sel, lcd_en=0.
- EN_HI (EN_HIGH_CYC cycles):
  - lcd_en=1.
  - On the edge ending the last EN_HI cycle: rdata ← lcd_data_in. If status read, also busy_flag ← bit 7, addr ← bits 6:0, poll_count += 1.
- HOLD (HOLD_CYC cycles): lcd_en=0; lcd_rw/lcd_rs held; rd_active=1.
- RECOVER (RECOVER_CYC cycles): rd_active=0, lcd_rw=0, lcd_rs=0, lcd_en=0. On exit:
  - poll=1, busy_flag=1, poll_count<POLL_MAX → SETUP.
  - poll=1, busy_flag=1, poll_count=POLL_MAX → set timeout=1, go to IDLE.
  - Otherwise → IDLE.
- done is registered and high for exactly the first IDLE cycle after RECOVER. A start in that cycle is accepted, giving back-to-back transactions.
- Latency (single read, default parameters):
  - Start sampled at edge 0 → SETUP from cycle 1; EN rises cycle 4, falls cycle 16; rdata valid from cycle 16.
  - rd_active drops cycle 18; done in cycle 28.
- Counters: one phase down-counter, width $clog2 of the largest *_CYC; reloaded at every state entry.
- poll_count saturates at POLL_MAX.
- Outputs are registered; lcd_en has no combinational path from inputs.
- Reset mid-transaction: lcd_en/rd_active drop immediately, no done, rdata returns to 0.

Decomposition:
- lcd_pkg holds:
  - the state enum (IDLE, SETUP, EN_HI, HOLD, RECOVER);
  - LCD_RS_STATUS/LCD_RS_DATA constants;
  - default timing constants, shared with the write path.
- No sub-module; the phase counter stays inline.

Test Plan:
- Status read, lcd_data_in=8'h4A, rs_sel=0, poll=0 → one EN pulse of 12 cycles starting 3 cycles after rd_active; done at cycle 28; rdata=8'h4A, busy_flag=0, addr=7'h4A, poll_count=1.
- Data read, rs_sel=1, lcd_data_in=8'h41 → lcd_rs=1 through SETUP/EN_HI/HOLD; rdata=8'h41; busy_flag/addr unchanged from prior status read.
- Poll, lcd_data_in=8'h80 for the first 2 EN pulses then 8'h05 → 3 EN pulses; done once; rdata=8'h05, busy_flag=0, poll_count=3, timeout=0.
- Poll timeout, POLL_MAX=4, lcd_data_in=8'hFF → 4 EN pulses; done with timeout=1, busy_flag=1, poll_count=4.
- rst asserted mid-EN_HI → lcd_en=0 and rd_active=0 before the next edge; no done; next start runs a normal 28-cycle read.
- start held high during a transaction and again in the done cycle → first transaction unchanged; second accepted in the done cycle; SETUP re-entered next cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus engines.
// Holds the read FSM states, RS encodings and default HD44780 timing.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_RECOVER
    } lcd_rd_state_e;

    localparam logic LCD_RS_STATUS = 1'b0;
    localparam logic LCD_RS_DATA   = 1'b1;

    // Cycle counts at 50 MHz (20 ns period).
    localparam int LCD_SETUP_CYC   = 3;
    localparam int LCD_EN_HIGH_CYC = 12;
    localparam int LCD_HOLD_CYC    = 2;
    localparam int LCD_RECOVER_CYC = 10;
    localparam int LCD_POLL_MAX    = 4096;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_read_engine.sv
// HD44780 read-cycle engine: status/data reads with optional BF polling.
// Owns the LCD bus while rd_active is high; all outputs are registered.
module lcd_read_engine
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC   = LCD_SETUP_CYC,
    parameter int EN_HIGH_CYC = LCD_EN_HIGH_CYC,
    parameter int HOLD_CYC    = LCD_HOLD_CYC,
    parameter int RECOVER_CYC = LCD_RECOVER_CYC,
    parameter int POLL_MAX    = LCD_POLL_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rs_sel,
    input  logic        poll,
    input  logic [7:0]  lcd_data_in,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        rd_active,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        busy_flag,
    output logic [6:0]  addr,
    output logic        timeout,
    output logic [12:0] poll_count
);

    localparam int MAXC = max4(SETUP_CYC, EN_HIGH_CYC,
                               HOLD_CYC, RECOVER_CYC);
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [12:0] PMAX = 13'(POLL_MAX);

    lcd_rd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, poll_q;
    logic          lcd_en_q, lcd_rs_q, lcd_rw_q, rd_active_q;
    logic          busy_q, done_q, bf_q, timeout_q;
    logic [7:0]    rdata_q;
    logic [6:0]    addr_q;
    logic [12:0]   pc_q;

    logic accept, sample, phase_end, poll_again, poll_expired;
    logic rs_nxt, drive_nxt;

    assign accept       = (state_q == ST_IDLE) && start;
    assign phase_end    = (cnt_q == '0);
    assign sample       = (state_q == ST_EN_HI) && phase_end;
    assign poll_again   = poll_q && bf_q && (pc_q < PMAX);
    assign poll_expired = poll_q && bf_q && !(pc_q < PMAX);
    assign rs_nxt       = accept ? rs_sel : rs_q;
    assign drive_nxt    = (state_d == ST_SETUP) ||
                          (state_d == ST_EN_HI) ||
                          (state_d == ST_HOLD);

    // Next state and phase counter; counter reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (phase_end) state_d = ST_EN_HI;
                else           cnt_d = cnt_q - CW'(1);
            end
            ST_EN_HI: begin
                if (phase_end) state_d = ST_HOLD;
                else           cnt_d = cnt_q - CW'(1);
            end
            ST_HOLD: begin
                if (phase_end) state_d = ST_RECOVER;
                else           cnt_d = cnt_q - CW'(1);
            end
            ST_RECOVER: begin
                if (phase_end) state_d = poll_again ? ST_SETUP : ST_IDLE;
                else           cnt_d = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                ST_SETUP:   cnt_d = CW'(SETUP_CYC - 1);
                ST_EN_HI:   cnt_d = CW'(EN_HIGH_CYC - 1);
                ST_HOLD:    cnt_d = CW'(HOLD_CYC - 1);
                ST_RECOVER: cnt_d = CW'(RECOVER_CYC - 1);
                default:    cnt_d = '0;
            endcase
        end
    end

    // State register, request latch and read-result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rs_q      <= LCD_RS_STATUS;
            poll_q    <= 1'b0;
            rdata_q   <= '0;
            bf_q      <= 1'b0;
            addr_q    <= '0;
            pc_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rs_q      <= rs_sel;
                poll_q    <= poll && (rs_sel == LCD_RS_STATUS);
                timeout_q <= 1'b0;
                pc_q      <= '0;
            end
            if (sample) begin
                rdata_q <= lcd_data_in;
                if (rs_q == LCD_RS_STATUS) begin
                    bf_q   <= lcd_data_in[7];
                    addr_q <= lcd_data_in[6:0];
                    if (pc_q < PMAX) pc_q <= pc_q + 13'd1;
                end
            end
            if ((state_q == ST_RECOVER) && phase_end && poll_expired)
                timeout_q <= 1'b1;
        end
    end

    // Bus strobes and status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_en_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            rd_active_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lcd_en_q    <= (state_d == ST_EN_HI);
            lcd_rs_q    <= drive_nxt && rs_nxt;
            lcd_rw_q    <= drive_nxt;
            rd_active_q <= drive_nxt;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_q == ST_RECOVER) && (state_d == ST_IDLE);
        end
    end

    assign lcd_en     = lcd_en_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = lcd_rw_q;
    assign rd_active  = rd_active_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign busy_flag  = bf_q;
    assign addr       = addr_q;
    assign timeout    = timeout_q;
    assign poll_count = pc_q;

endmodule
